alu_rr_scheduler: RTL and testbench

Shares one instance of the team's combinational 8-bit `alu` between NUM_REQ requesters.
- Arbitrates round-robin and registers the winner's operands.
- Registers the ALU outputs and returns them on a single tagged response channel with valid/ready backpressure.
- Sits between requesting datapath blocks and the shared ALU. Provides per-requester enable masking and a transaction counter.

---
 rtl/alu_sched_pkg.sv | 21 ++
 rtl/alu.sv | 34 +++
 rtl/rr_arbiter.sv | 31 +++
 rtl/alu_rr_scheduler.sv | 146 ++++++++++++++
 tb/tb_alu_rr_scheduler.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_sched_pkg.sv
// Shared types for the round-robin ALU scheduler: ALU opcodes and scheduler FSM states.
package alu_sched_pkg;

  typedef enum logic [2:0] {
    OpAdd = 3'b000,
    OpSub = 3'b001,
    OpAnd = 3'b010,
    OpOr  = 3'b011,
    OpXor = 3'b100,
    OpNot = 3'b101,
    OpSll = 3'b110,
    OpSrl = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StResp = 2'b10
  } sched_state_e;

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU. SUB reports borrow on carry; shifts move by one bit, SLL carries out a[7].
module alu
  import alu_sched_pkg::*;
(
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  alu_op_e    i_op,
  output logic [7:0] o_result,
  output logic       o_zero,
  output logic       o_carry
);

  always_comb begin
    o_result = 8'h00;
    o_carry  = 1'b0;
    unique case (i_op)
      OpAdd: {o_carry, o_result} = {1'b0, i_a} + {1'b0, i_b};
      OpSub: {o_carry, o_result} = {1'b0, i_a} - {1'b0, i_b};
      OpAnd: o_result = i_a & i_b;
      OpOr:  o_result = i_a | i_b;
      OpXor: o_result = i_a ^ i_b;
      OpNot: o_result = ~i_a;
      OpSll: {o_carry, o_result} = {i_a, 1'b0};
      OpSrl: o_result = {1'b0, i_a[7:1]};
      default: begin
        o_result = 8'h00;
        o_carry  = 1'b0;
      end
    endcase
  end

  assign o_zero = (o_result == 8'h00);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first eligible bit searching upward from i_ptr+1 with wrap.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_eligible,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [IW-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    // k = N wraps back to the previous winner, so it has lowest priority.
    for (int k = 1; k <= int'(N); k++) begin
      w_cand = IW'((int'(i_ptr) + k) % int'(N));
      if (!o_any && i_eligible[w_cand]) begin
        o_any           = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one combinational ALU between NUM_REQ requesters: round-robin grant, registered
// operands and results, single tagged valid/ready response channel and a completion counter.
module alu_rr_scheduler
  import alu_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ),
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*8-1:0] req_a,
  input  logic [NUM_REQ*8-1:0] req_b,
  input  logic [NUM_REQ*3-1:0] req_op,
  input  logic [NUM_REQ-1:0]   req_en_mask,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_result,
  output logic                 rsp_zero,
  output logic                 rsp_carry,
  output logic                 busy,
  output logic [CNT_W-1:0]     done_count
);

  sched_state_e r_state, w_state_next;

  logic [ID_W-1:0]    r_ptr;
  logic [7:0]         r_a, r_b;
  alu_op_e            r_op;
  logic [ID_W-1:0]    r_id;
  logic               r_rsp_valid;
  logic [ID_W-1:0]    r_rsp_id;
  logic [7:0]         r_rsp_result;
  logic               r_rsp_zero;
  logic               r_rsp_carry;
  logic [CNT_W-1:0]   r_done_count;

  logic [NUM_REQ-1:0] w_eligible, w_grant;
  logic [ID_W-1:0]    w_idx;
  logic               w_any;
  logic               w_accept, w_complete;
  logic [7:0]         w_alu_result;
  logic               w_alu_zero, w_alu_carry;

  assign w_eligible = req_valid & req_en_mask;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_arb (
    .i_eligible (w_eligible),
    .i_ptr      (r_ptr),
    .o_grant    (w_grant),
    .o_idx      (w_idx),
    .o_any      (w_any)
  );

  alu u_alu (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_op     (r_op),
    .o_result (w_alu_result),
    .o_zero   (w_alu_zero),
    .o_carry  (w_alu_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    req_ready    = '0;
    w_accept     = 1'b0;
    w_complete   = 1'b0;
    unique case (r_state)
      StIdle: begin
        // Grant only when not in reset so no handshake is signalled that would be dropped.
        if (w_any && !rst) begin
          req_ready    = w_grant;
          w_accept     = 1'b1;
          w_state_next = StExec;
        end
      end
      StExec: w_state_next = StResp;
      StResp: begin
        if (rsp_ready) begin
          w_complete   = 1'b1;
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr        <= ID_W'(NUM_REQ - 1);
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= OpAdd;
      r_id         <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_carry  <= 1'b0;
      r_done_count <= '0;
    end else begin
      if (w_accept) begin
        r_a   <= req_a[{w_idx, 3'b000} +: 8];
        r_b   <= req_b[{w_idx, 3'b000} +: 8];
        r_op  <= alu_op_e'(req_op[3 * w_idx +: 3]);
        r_id  <= w_idx;
        r_ptr <= w_idx;
      end
      if (r_state == StExec) begin
        r_rsp_valid  <= 1'b1;
        r_rsp_id     <= r_id;
        r_rsp_result <= w_alu_result;
        r_rsp_zero   <= w_alu_zero;
        r_rsp_carry  <= w_alu_carry;
      end
      if (w_complete) begin
        r_rsp_valid  <= 1'b0;
        r_done_count <= r_done_count + CNT_W'(1);
      end
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign rsp_zero   = r_rsp_zero;
  assign rsp_carry  = r_rsp_carry;
  assign busy       = (r_state != StIdle);
  assign done_count = r_done_count;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler: vector table of single transactions plus
// round-robin, backpressure, masking and reset-in-flight sequences.
module tb_alu_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_ready, req_en_mask;
  logic [31:0] req_a, req_b;
  logic [11:0] req_op;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_result;
  logic        rsp_zero, rsp_carry, busy;
  logic [15:0] done_count;

  int checks   = 0;
  int failures = 0;
  int exp_done = 0;

  typedef struct {
    int         req;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] res;
    logic       zero;
    logic       carry;
    logic       chk_c;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  alu_rr_scheduler #(
    .NUM_REQ (4),
    .ID_W    (2),
    .CNT_W   (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .req_en_mask (req_en_mask),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_result  (rsp_result),
    .rsp_zero    (rsp_zero),
    .rsp_carry   (rsp_carry),
    .busy        (busy),
    .done_count  (done_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int r, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op);
    req_a[8*r +: 8] = a;
    req_b[8*r +: 8] = b;
    req_op[3*r +: 3] = op;
  endtask

  // Full transaction with rsp_ready high: grant, EXEC, RESP, back to IDLE.
  task automatic run_txn(input vec_t v);
    logic [3:0] oh;
    oh = 4'b0001 << v.req;
    set_req(v.req, v.a, v.b, v.op);
    req_valid = oh;
    #1;
    chk("vec_grant", req_ready, oh);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    #1;
    chk("vec_exec_busy", busy, 1);
    chk("vec_exec_no_rsp", rsp_valid, 0);
    @(posedge clk); #2;
    chk("vec_rsp_valid", rsp_valid, 1);
    chk("vec_rsp_id", rsp_id, v.req);
    chk("vec_result", rsp_result, v.res);
    chk("vec_zero", rsp_zero, v.zero);
    if (v.chk_c) chk("vec_carry", rsp_carry, v.carry);
    @(posedge clk); #2;
    exp_done++;
    chk("vec_rsp_clear", rsp_valid, 0);
    chk("vec_done_count", done_count, exp_done);
    chk("vec_idle", busy, 0);
  endtask

  initial begin
    //          req  a      b      op      res    z     c     chk_c
    vecs[0] = '{0, 8'd200, 8'd100, 3'b000, 8'd44,  1'b0, 1'b1, 1'b1};
    vecs[1] = '{2, 8'd5,   8'd10,  3'b001, 8'd251, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{2, 8'd7,   8'd7,   3'b001, 8'd0,   1'b1, 1'b0, 1'b1};
    vecs[3] = '{1, 8'hF0,  8'h3C,  3'b010, 8'h30,  1'b0, 1'b0, 1'b0};
    vecs[4] = '{3, 8'hF0,  8'h0F,  3'b011, 8'hFF,  1'b0, 1'b0, 1'b0};
    vecs[5] = '{0, 8'hAA,  8'hAA,  3'b100, 8'h00,  1'b1, 1'b0, 1'b0};
    vecs[6] = '{1, 8'h0F,  8'h00,  3'b101, 8'hF0,  1'b0, 1'b0, 1'b0};
    vecs[7] = '{3, 8'h81,  8'h01,  3'b110, 8'h02,  1'b0, 1'b1, 1'b1};
    vecs[8] = '{2, 8'h81,  8'h01,  3'b111, 8'h40,  1'b0, 1'b0, 1'b0};
    vecs[9] = '{0, 8'hFF,  8'h01,  3'b000, 8'h00,  1'b1, 1'b1, 1'b1};

    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_op = '0;
    req_en_mask = 4'hF; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_flags", {rsp_zero, rsp_carry}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done_count, 0);

    for (int i = 0; i < 10; i++) run_txn(vecs[i]);

    // Round-robin from reset: all four valid, grants 0,1,2,3,0 three cycles apart.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; exp_done = 0;
    for (int r = 0; r < 4; r++) set_req(r, 8'(r), 8'd1, 3'b000);
    req_valid = 4'hF;
    #1;
    for (int c = 0; c < 15; c++) begin
      chk("rr_ready", req_ready, (c % 3 == 0) ? (4'b0001 << ((c / 3) % 4)) : 4'b0000);
      if (c % 3 == 2) begin
        chk("rr_rsp_valid", rsp_valid, 1);
        chk("rr_rsp_id", rsp_id, (c / 3) % 4);
        chk("rr_result", rsp_result, ((c / 3) % 4) + 1);
      end
      @(posedge clk); #2;
    end
    req_valid = 4'h0;
    exp_done = 5;
    chk("rr_done", done_count, exp_done);

    // Backpressure: pointer is at 0, so req1 wins over req0; response held for 5 stalled cycles.
    set_req(1, 8'h81, 8'h01, 3'b110);
    rsp_ready = 1'b0;
    req_valid = 4'b0011;
    #1;
    chk("bp_grant", req_ready, 4'b0010);
    @(posedge clk); #1;
    req_valid = 4'b0001;
    @(posedge clk); #2;
    for (int s = 0; s < 5; s++) begin
      chk("bp_valid_held", rsp_valid, 1);
      chk("bp_result", rsp_result, 8'h02);
      chk("bp_carry", rsp_carry, 1);
      chk("bp_id", rsp_id, 1);
      chk("bp_no_grant", req_ready, 0);
      @(posedge clk); #2;
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_still_valid", rsp_valid, 1);
    @(posedge clk); #2;
    exp_done++;
    chk("bp_released", rsp_valid, 0);
    chk("bp_done", done_count, exp_done);
    chk("bp_next_grant", req_ready, 4'b0001);
    req_valid = 4'b0000;
    #1;

    // Masking: req1 masked out, only req3 may win; req1 follows once unmasked.
    set_req(3, 8'd1, 8'd2, 3'b000);
    req_en_mask = 4'b1101;
    req_valid   = 4'b1010;
    #1;
    chk("mask_grant3", req_ready, 4'b1000);
    @(posedge clk); #1;
    req_valid = 4'b0010;
    @(posedge clk); #2;
    chk("mask_rsp_id3", rsp_id, 3);
    chk("mask_result3", rsp_result, 8'd3);
    @(posedge clk); #2;
    exp_done++;
    chk("mask_done", done_count, exp_done);
    chk("mask_blocked", req_ready, 0);
    req_en_mask = 4'hF;
    #1;
    chk("mask_grant1", req_ready, 4'b0010);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    @(posedge clk); #2;
    chk("mask_rsp_id1", rsp_id, 1);
    chk("mask_result1", rsp_result, 8'h02);
    @(posedge clk); #2;
    exp_done++;
    chk("mask_done2", done_count, exp_done);

    // Reset while stalled in RESP drops the response and restarts priority at requester 0.
    set_req(2, 8'd5, 8'd10, 3'b001);
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    #1;
    chk("rr6_grant", req_ready, 4'b0100);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    @(posedge clk); #2;
    chk("rr6_in_resp", rsp_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rr6_rsp_valid", rsp_valid, 0);
    chk("rr6_busy", busy, 0);
    chk("rr6_done", done_count, 0);
    chk("rr6_result", rsp_result, 0);
    req_valid = 4'hF;
    #1;
    chk("rr6_first_grant", req_ready, 4'b0001);
    req_valid = 4'h0;
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
